// File: rtl/axi_slave_rd_responder.sv
// AXI read-channel responder: queues AR requests and answers each burst with
// lane-indexed pattern data (or SLVERR for unsupported bursts/sizes).
module axi_slave_rd_responder #(
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ARUSER_WIDTH = 8,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [31:0]             cfg_init_data,
    input  logic [3:0]              cfg_gap,
    output logic [31:0]             stat_burst_count,
    output logic [39:0]             stat_beat_count,
    output logic                    stat_busy
);
    localparam int unsigned PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int unsigned LANES    = DATA_WIDTH / 32;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_t;

    ar_t                   fifo_q [QUEUE_DEPTH];
    ar_t                   fifo_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  arready_q, arready_d;
    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d, beat_idx_q, beat_idx_d, next_idx;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d, next_addr;
    logic                  err_q, err_d;
    logic [31:0]           init_q, init_d;
    logic [3:0]            gap_q, gap_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           burst_cnt_q, burst_cnt_d;
    logic [39:0]           beat_cnt_q, beat_cnt_d;
    logic                  push, pop, head_err;
    ar_t                   head;
    logic                  unused_aruser;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] init,
                                                      input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] d;
        logic [31:0]           base;
        base = init + addr[33:2];
        d    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            d[32*k +: 32] = base + 32'(k);
        end
        return d;
    endfunction

    assign unused_aruser = ^s_axi_aruser;
    assign push          = s_axi_arvalid && arready_q;
    assign pop           = (state_q == IDLE) && (count_q != '0);
    assign head          = fifo_q[rd_ptr_q];
    assign head_err      = (head.burst != 2'b01) || (head.size > 3'(MAX_SIZE));
    assign next_addr     = beat_addr_q + (ADDR_WIDTH'(1) << size_q);
    assign next_idx      = beat_idx_q + 8'd1;

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        len_d       = len_q;
        size_d      = size_q;
        beat_addr_d = beat_addr_q;
        beat_idx_d  = beat_idx_q;
        err_d       = err_q;
        init_d      = init_q;
        gap_d       = gap_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        burst_cnt_d = burst_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        if (push) begin
            fifo_d[wr_ptr_q] = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                                 size: s_axi_arsize, burst: s_axi_arburst};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        // arready is registered from the post-update occupancy, so a full queue
        // refuses a new AR even in a cycle where the head is being popped.
        arready_d = (count_d != CNT_W'(QUEUE_DEPTH));

        case (state_q)
            IDLE: begin
                if (pop) begin
                    len_d       = head.len;
                    size_d      = head.size;
                    beat_addr_d = head.addr;
                    beat_idx_d  = '0;
                    err_d       = head_err;
                    init_d      = cfg_init_data;
                    rvalid_d    = 1'b1;
                    rid_d       = head.id;
                    rresp_d     = head_err ? 2'b10 : 2'b00;
                    rdata_d     = head_err ? '0 : pattern(cfg_init_data, head.addr);
                    rlast_d     = (head.len == 8'd0);
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (s_axi_rready) begin
                    beat_cnt_d = beat_cnt_q + 40'd1;
                    if (rlast_q) begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        rvalid_d    = 1'b0;
                        rlast_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        // Next beat is prepared now and stays parked through any gap.
                        beat_addr_d = next_addr;
                        beat_idx_d  = next_idx;
                        rdata_d     = err_q ? '0 : pattern(init_q, next_addr);
                        rlast_d     = (next_idx == len_q);
                        if (cfg_gap != 4'd0) begin
                            gap_d    = cfg_gap;
                            rvalid_d = 1'b0;
                            state_d  = GAP;
                        end
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    rvalid_d = 1'b1;
                    state_d  = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            arready_q   <= 1'b1;
            state_q     <= IDLE;
            len_q       <= '0;
            size_q      <= '0;
            beat_addr_q <= '0;
            beat_idx_q  <= '0;
            err_q       <= 1'b0;
            init_q      <= '0;
            gap_q       <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            arready_q   <= arready_d;
            state_q     <= state_d;
            len_q       <= len_d;
            size_q      <= size_d;
            beat_addr_q <= beat_addr_d;
            beat_idx_q  <= beat_idx_d;
            err_q       <= err_d;
            init_q      <= init_d;
            gap_q       <= gap_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            burst_cnt_q <= burst_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign s_axi_arready    = arready_q;
    assign s_axi_rvalid     = rvalid_q;
    assign s_axi_rid        = rid_q;
    assign s_axi_rdata      = rdata_q;
    assign s_axi_rresp      = rresp_q;
    assign s_axi_rlast      = rlast_q;
    assign stat_burst_count = burst_cnt_q;
    assign stat_beat_count  = beat_cnt_q;
    assign stat_busy        = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_axi_slave_rd_responder.sv
// Scoreboard bench for axi_slave_rd_responder: stimulus queues expected beats,
// a negedge monitor pops and compares each R handshake and checks stall stability.
module tb_axi_slave_rd_responder;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    arid = '0;
    logic [63:0]   araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic [7:0]    aruser = 8'hA5;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [1:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid;
    logic          rready = 1'b0;
    logic [31:0]   cfg_init_data = '0;
    logic [3:0]    cfg_gap = '0;
    logic [31:0]   stat_burst_count;
    logic [39:0]   stat_beat_count;
    logic          stat_busy;

    axi_slave_rd_responder #(.ID_WIDTH(2), .ADDR_WIDTH(64), .DATA_WIDTH(DW),
                             .ARUSER_WIDTH(8), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_aruser(aruser),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .cfg_init_data(cfg_init_data), .cfg_gap(cfg_gap),
        .stat_burst_count(stat_burst_count), .stat_beat_count(stat_beat_count),
        .stat_busy(stat_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    beat_no = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected beat with lane k = base + k (base hand-derived per test).
    task automatic push_hand(input logic [1:0] id, input logic [31:0] base, input logic last);
        beat_t e;
        e.id = id; e.resp = 2'b00; e.last = last;
        for (int k = 0; k < DW/32; k++) e.data[32*k +: 32] = base + 32'(k);
        sb.push_back(e);
    endtask

    task automatic push_burst(input logic [1:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [31:0] init);
        logic [63:0] a;
        logic        err;
        beat_t       e;
        a   = addr;
        err = (burst != 2'b01) || (size > 3'd6);
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            for (int k = 0; k < DW/32; k++) e.data[32*k +: 32] = err ? 32'd0 : init + a[33:2] + 32'(k);
            sb.push_back(e);
            a = a + (64'd1 << size);
        end
    endtask

    task automatic ar(input logic [1:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (arready) begin
                step();
                arvalid = 1'b0;
                return;
            end
            step();
        end
        arvalid = 1'b0;
        checks++; errors++;
        $display("FAIL ar_timeout arready got 0 want 1");
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (sb.size() == 0 && !stat_busy && !rvalid) return;
            step();
        end
        checks++; errors++;
        $display("FAIL drain_timeout pending %0d want 0", sb.size());
    endtask

    task automatic do_reset();
        sb.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: compare each handshake against the scoreboard, and check outputs hold while stalled.
    initial begin
        logic          prev_stall;
        logic [1:0]    p_id;
        logic [DW-1:0] p_data;
        logic [1:0]    p_resp;
        logic          p_last;
        beat_t         e;
        prev_stall = 1'b0;
        p_id = '0; p_data = '0; p_resp = '0; p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && rvalid) begin
                if (prev_stall) begin
                    checks++;
                    if (rid !== p_id || rdata !== p_data || rresp !== p_resp || rlast !== p_last) begin
                        errors++;
                        $display("FAIL stall_hold id=%0h/%0h last=%0b/%0b resp=%0h/%0h data changed=%0b want 0",
                                 rid, p_id, rlast, p_last, rresp, p_resp, rdata !== p_data);
                    end
                end
                if (rready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat id=%0h last=%0b got beat want none", rid, rlast);
                    end else begin
                        e = sb.pop_front();
                        if (rid !== e.id || rresp !== e.resp || rlast !== e.last || rdata !== e.data) begin
                            errors++;
                            $display("FAIL beat%0d id=%0h/%0h resp=%0h/%0h last=%0b/%0b data=%h want %h",
                                     beat_no, rid, e.id, rresp, e.resp, rlast, e.last, rdata, e.data);
                        end
                    end
                    beat_no++;
                end
                prev_stall = !rready;
                p_id = rid; p_data = rdata; p_resp = rresp; p_last = rlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached want finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic       acc, last_ready, seen;
        int         n_acc;

        // Reset values
        rst = 1'b1;
        step(); step();
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_rdata_nonzero", 64'(rdata != '0), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_beats", 64'(stat_beat_count), 64'd0);
        chk("rst_bursts", 64'(stat_burst_count), 64'd0);
        chk("rst_busy", 64'(stat_busy), 64'd0);
        rst = 1'b0;
        step();

        // Basic INCR burst: 0x1000>>2 = 0x400, +0x100 -> 0x500; each 64B beat adds 0x10.
        cfg_init_data = 32'h100;
        rready = 1'b1;
        for (int b = 0; b < 4; b++) push_hand(2'd1, 32'h500 + 32'h10 * 32'(b), b == 3);
        ar(2'd1, 64'h1000, 8'd3, 3'd6, 2'b01);
        chk("lat_1cyc_rvalid", 64'(rvalid), 64'd0);
        step();
        chk("lat_2cyc_rvalid", 64'(rvalid), 64'd1);
        drain();
        chk("basic_beats", 64'(stat_beat_count), 64'd4);
        chk("basic_bursts", 64'(stat_burst_count), 64'd1);
        chk("basic_busy", 64'(stat_busy), 64'd0);

        // Address wrap at 2^64: lane0 = 0x10 + 0xFFFFFFF0 = 0, then addr 0 -> 0x10.
        do_reset();
        cfg_init_data = 32'h10;
        push_hand(2'd2, 32'h0, 1'b0);
        push_hand(2'd2, 32'h10, 1'b1);
        ar(2'd2, 64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 3'd6, 2'b01);
        drain();

        // SLVERR cases: oversize beat, then FIXED burst.
        do_reset();
        push_burst(2'd3, 64'h2000, 8'd1, 3'd7, 2'b01, 32'h0);
        push_burst(2'd0, 64'h40, 8'd0, 3'd2, 2'b00, 32'h0);
        ar(2'd3, 64'h2000, 8'd1, 3'd7, 2'b01);
        ar(2'd0, 64'h40, 8'd0, 3'd2, 2'b00);
        drain();
        chk("err_beats", 64'(stat_beat_count), 64'd3);
        chk("err_bursts", 64'(stat_burst_count), 64'd2);

        // Inter-beat gap of 2.
        do_reset();
        cfg_init_data = 32'h0;
        cfg_gap = 4'd2;
        for (int b = 0; b < 3; b++) push_hand(2'd1, 32'h10 * 32'(b), b == 2);
        ar(2'd1, 64'h0, 8'd2, 3'd6, 2'b01);
        pat = 8'b0100_1001;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("gap_rvalid_%0d", i), 64'(rvalid), 64'(pat[i]));
        end
        chk("gap_beats", 64'(stat_beat_count), 64'd3);
        chk("gap_bursts", 64'(stat_burst_count), 64'd1);
        cfg_gap = 4'd0;
        drain();

        // Back-to-back ARs with rready low: 1 working + 4 queued.
        do_reset();
        rready = 1'b0;
        cfg_init_data = 32'hABCD_0000;
        n_acc = 0;
        last_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            arid = 2'(i); araddr = 64'(i) * 64'h100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
            arvalid = 1'b1;
            acc = arready;
            last_ready = acc;
            if (acc) begin
                n_acc++;
                push_hand(2'(i), 32'hABCD_0000 + 32'h40 * 32'(i), 1'b1);
            end
            step();
        end
        arvalid = 1'b0;
        chk("full_accepted", 64'(n_acc), 64'd5);
        chk("full_6th_arready", 64'(last_ready), 64'd0);
        chk("full_busy", 64'(stat_busy), 64'd1);
        rready = 1'b1;
        drain();
        chk("full_beats", 64'(stat_beat_count), 64'd5);

        // Random backpressure across two bursts.
        do_reset();
        rready = 1'b0;
        cfg_init_data = 32'h1234_0000;
        push_burst(2'd2, 64'hFFC, 8'd7, 3'd2, 2'b01, 32'h1234_0000);
        push_burst(2'd1, 64'h3_0000_0080, 8'd3, 3'd6, 2'b01, 32'h1234_0000);
        ar(2'd2, 64'hFFC, 8'd7, 3'd2, 2'b01);
        ar(2'd1, 64'h3_0000_0080, 8'd3, 3'd6, 2'b01);
        for (int i = 0; i < 1000; i++) begin
            if (sb.size() == 0 && !stat_busy) break;
            rready = 1'($urandom_range(0, 1));
            step();
        end
        rready = 1'b1;
        drain();
        chk("rand_beats", 64'(stat_beat_count), 64'd12);
        chk("rand_bursts", 64'(stat_burst_count), 64'd2);

        // Reset during beat 2 of an 8-beat burst with two ARs still queued.
        do_reset();
        rready = 1'b0;
        cfg_init_data = 32'h0;
        push_hand(2'd1, 32'h0, 1'b0);
        push_hand(2'd1, 32'h10, 1'b0);
        ar(2'd1, 64'h0, 8'd7, 3'd6, 2'b01);
        ar(2'd2, 64'h400, 8'd7, 3'd6, 2'b01);
        ar(2'd3, 64'h800, 8'd7, 3'd6, 2'b01);
        rready = 1'b1;
        step(); step();
        rready = 1'b0;
        chk("abort_pre_rvalid", 64'(rvalid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rvalid", 64'(rvalid), 64'd0);
        chk("abort_rlast", 64'(rlast), 64'd0);
        chk("abort_rid", 64'(rid), 64'd0);
        chk("abort_rdata_nonzero", 64'(rdata != '0), 64'd0);
        chk("abort_rresp", 64'(rresp), 64'd0);
        chk("abort_arready", 64'(arready), 64'd1);
        chk("abort_beats", 64'(stat_beat_count), 64'd0);
        chk("abort_bursts", 64'(stat_burst_count), 64'd0);
        chk("abort_busy", 64'(stat_busy), 64'd0);
        rready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rvalid) seen = 1'b1;
        end
        chk("abort_no_beats", 64'(seen), 64'd0);
        chk("abort_idle_busy", 64'(stat_busy), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
